// File: rtl/clock_enable_divider.sv
// clock_enable_divider: multi-channel programmable clock-enable generator.
// Each channel gives a one-cycle tick and a near-50% square wave, optionally cascaded.
module clock_enable_divider #(
    parameter int WIDTH       = 16,
    parameter int NUM_CH      = 2,
    parameter int DEFAULT_DIV = 2500,
    parameter int CASCADE     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic [NUM_CH*WIDTH-1:0]  div_ch,
    output logic [NUM_CH-1:0]        tick_o,
    output logic [NUM_CH-1:0]        sq_o,
    output logic [NUM_CH*WIDTH-1:0]  cnt_o
);
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] tc;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] d_act;
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] cnt_nx;
        logic             tick;
        logic             sq;

        assign div    = div_ch[g*WIDTH +: WIDTH];
        assign cnt_nx = cnt + 1'b1;
        if (CASCADE != 0 && g > 0) begin : g_casc
            assign ce[g] = tc[g-1];
        end else begin : g_ind
            assign ce[g] = en;
        end
        assign tc[g] = ce[g] && !clr && d_act != '0 && cnt == d_act - 1'b1;
        assign cnt_o[g*WIDTH +: WIDTH] = cnt;
        assign tick_o[g] = tick;
        assign sq_o[g]   = sq;

        // Divisor is only re-sampled at wrap (or while idle/cleared) so periods never glitch.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                d_act <= WIDTH'(DEFAULT_DIV);
                tick  <= 1'b0;
                sq    <= 1'b0;
            end else if (clr || d_act == '0) begin
                cnt   <= '0;
                d_act <= div;
                tick  <= 1'b0;
                sq    <= 1'b0;
            end else if (tc[g]) begin
                cnt   <= '0;
                d_act <= div;
                tick  <= 1'b1;
                sq    <= (div >> 1) == '0;
            end else if (ce[g]) begin
                cnt   <= cnt_nx;
                tick  <= 1'b0;
                sq    <= cnt_nx >= (d_act >> 1);
            end else begin
                tick  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clock_enable_divider.sv
// tb_clock_enable_divider: directed and random checks of an independent and a cascaded divider
// against an integer period/position reference model.
module tb_clock_enable_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] div_a = 16'h0404;
    logic [15:0] div_b = 16'h0304;
    logic [1:0]  tick_a, sq_a, tick_b, sq_b;
    logic [15:0] cnt_a, cnt_b;
    int checks = 0;
    int errors = 0;
    int pos [2][2];
    int per [2][2];
    int tk  [2][2];
    int sqm [2][2];

    always #5 clk = ~clk;

    clock_enable_divider #(.WIDTH(8), .NUM_CH(2), .DEFAULT_DIV(4), .CASCADE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .div_ch(div_a),
        .tick_o(tick_a), .sq_o(sq_a), .cnt_o(cnt_a));
    clock_enable_divider #(.WIDTH(8), .NUM_CH(2), .DEFAULT_DIV(4), .CASCADE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .div_ch(div_b),
        .tick_o(tick_b), .sq_o(sq_b), .cnt_o(cnt_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dv(int d, int k);
        logic [15:0] v;
        v = (d == 0) ? div_a : div_b;
        return int'(v[8*k +: 8]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 2; k++) begin
                pos[d][k] = 0; per[d][k] = 4; tk[d][k] = 0; sqm[d][k] = 0;
            end
    endtask

    // A period of per cycles: position advances on each enabled cycle, wraps with a tick.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int wrap_prev = 0;
            for (int k = 0; k < 2; k++) begin
                int ce, wrap;
                ce = (d == 1 && k == 1) ? wrap_prev : int'(en);
                wrap = (!clr && ce != 0 && per[d][k] != 0 && pos[d][k] == per[d][k] - 1) ? 1 : 0;
                if (clr || per[d][k] == 0) begin
                    pos[d][k] = 0; per[d][k] = dv(d, k); tk[d][k] = 0; sqm[d][k] = 0;
                end else if (ce != 0) begin
                    if (wrap != 0) begin
                        pos[d][k] = 0; per[d][k] = dv(d, k); tk[d][k] = 1;
                    end else begin
                        pos[d][k]++; tk[d][k] = 0;
                    end
                    sqm[d][k] = (pos[d][k] >= per[d][k] / 2) ? 1 : 0;
                end else begin
                    tk[d][k] = 0;
                end
                wrap_prev = wrap;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model d%0d ch%0d tick", d, k), d == 0 ? tick_a[k] : tick_b[k], tk[d][k]);
                chk($sformatf("model d%0d ch%0d sq", d, k), d == 0 ? sq_a[k] : sq_b[k], sqm[d][k]);
                chk($sformatf("model d%0d ch%0d cnt", d, k),
                    d == 0 ? cnt_a[8*k +: 8] : cnt_b[8*k +: 8], pos[d][k]);
            end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        while (int'(cnt_a[7:0]) != target && n < 20) begin
            cyc(1);
            n++;
        end
        chk("reach cnt", cnt_a[7:0], target);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        chk("reset tick_a", tick_a, 0);
        chk("reset sq_a", sq_a, 0);
        chk("reset cnt_a", cnt_a, 0);
        chk("reset tick_b", tick_b, 0);
        chk("reset cnt_b", cnt_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            chk("basic cnt", cnt_a[7:0], i % 4);
            chk("basic tick", tick_a[0], (i % 4 == 0) ? 1 : 0);
            chk("basic sq", sq_a[0], (i % 4 >= 2) ? 1 : 0);
        end
        div_a = 16'h0505;
        pulse_clr();
        for (int i = 1; i <= 15; i++) begin
            cyc(1);
            chk("odd tick", tick_a[0], (i % 5 == 0) ? 1 : 0);
            chk("odd sq", sq_a[0], (i % 5 >= 2) ? 1 : 0);
        end
        div_a = 16'h0a0a;
        pulse_clr();
        cyc(4);
        chk("mid cnt", cnt_a[7:0], 4);
        div_a = 16'h0303;
        for (int j = 1; j <= 15; j++) begin
            cyc(1);
            chk("mid tick", tick_a[0], (j == 6 || (j > 6 && (j - 6) % 3 == 0)) ? 1 : 0);
        end
        div_a = 16'h0000;
        pulse_clr();
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("idle tick", tick_a, 0);
            chk("idle sq", sq_a, 0);
            chk("idle cnt", cnt_a, 0);
        end
        div_a = 16'h0101;
        cyc(1);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("n1 tick", tick_a, 2'b11);
            chk("n1 sq", sq_a, 2'b11);
        end
        div_b = 16'h0304;
        pulse_clr();
        begin
            int t0 = 0, t1 = 0;
            logic [15:0] held;
            for (int i = 1; i <= 24; i++) begin
                cyc(1);
                t0 += int'(tick_b[0]);
                t1 += int'(tick_b[1]);
                chk("casc coincide", tick_b[1] & ~tick_b[0], 0);
            end
            chk("casc ch0 ticks", t0, 6);
            chk("casc ch1 ticks", t1, 2);
            cyc(5);
            en = 1'b0;
            held = cnt_b;
            for (int i = 0; i < 5; i++) begin
                cyc(1);
                chk("freeze cnt", cnt_b, held);
                chk("freeze tick", tick_b, 0);
            end
            en = 1'b1;
        end
        div_a = 16'h0404;
        pulse_clr();
        wait_cnt(3);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("clr tick", tick_a[0], 0);
        chk("clr cnt", cnt_a[7:0], 0);
        div_a = 16'h0606;
        wait_cnt(2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst tick", {tick_a, tick_b}, 0);
        chk("arst sq", {sq_a, sq_b}, 0);
        chk("arst cnt", {cnt_a, cnt_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            chk("arst default tick", tick_a[0], (i == 4) ? 1 : 0);
        end
        for (int i = 0; i < 400; i++) begin
            en = $urandom_range(0, 9) != 0;
            clr = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 9) == 0) div_a = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
            if ($urandom_range(0, 9) == 0) div_b = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 6))};
            cyc(1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_enable_divider.md
Name: clock_enable_divider

Overview:
- Parametrised multi-channel clock-enable generator. Each channel divides the system clock by a runtime-programmable divisor.
- Per channel it produces a one-cycle tick strobe and a near-50% square wave, both registered and synchronous to clk.
- Channels can run independently or as a cascade, where channel k advances only on channel k-1 terminal count. This supports stopwatch timebases such as 100 MHz -> 1 ms -> 10 ms without extra clock domains.

Parameters:
- WIDTH, 16, width of each channel's counter and divisor.
- NUM_CH, 2, number of divider channels (>=1).
- DEFAULT_DIV, 2500, divisor loaded into every channel at reset; must fit in WIDTH bits.
- CASCADE, 0, 0 = all channels count on en; 1 = channel k>0 counts only on channel k-1 terminal count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global count enable (channel 0 enable in cascade mode).
- clr  in  1  synchronous restart of all channels.
- div_ch  in  NUM_CH*WIDTH  requested divisor per channel; channel k in bits [k*WIDTH +: WIDTH], unsigned.
- tick_o  out  NUM_CH  one-cycle strobe per channel at period end.
- sq_o  out  NUM_CH  square wave per channel.
- cnt_o  out  NUM_CH*WIDTH  current counter value per channel (debug/display).

Behaviour:
- Per-channel state: cnt (WIDTH), active divisor d_act (WIDTH), tick_o bit, sq_o bit.
- Reset (rst_n=0, async): cnt=0, d_act=DEFAULT_DIV, tick_o=0, sq_o=0, cnt_o=0.
- Channel enable ce_k:
  - CASCADE=0: ce_k = en.
  - CASCADE=1: ce_0 = en; ce_k = tc_(k-1).
- Terminal count is combinational, not registered: tc_k = ce_k && d_act!=0 && cnt==d_act-1.
- Priority per edge is clr > d_act==0 idle > ce_k > hold.
- clr=1:
  - cnt<=0, tick_o<=0, sq_o<=0.
  - d_act<=div_ch[k], loaded immediately.
  - tc forced 0 that cycle.
- d_act==0 (channel idle):
  - cnt<=0, tick_o<=0, sq_o<=0.
  - d_act<=div_ch[k] every cycle, so writing a nonzero divisor starts the channel on the next edge.
- ce_k=1 and tc_k=1:
  - cnt<=0, tick_o<=1.
  - d_act<=div_ch[k]; the divisor reloads only here, so every period is glitch-free.
- ce_k=1, tc_k=0: cnt<=cnt+1, tick_o<=0.
- ce_k=0: cnt and d_act hold, tick_o<=0, sq_o holds.
- sq_o update, whenever cnt updates: sq_o <= (cnt_next >= floor(d_next/2)), where d_next is the post-update d_act.
  - Period is N enabled cycles, high for ceil(N/2).
  - sq_o falls on the same edge that tick_o rises.
- Divisor changes:
  - A new div_ch mid-period takes effect only at that channel's next terminal count.
  - N=1 gives tick_o high on every enabled cycle and sq_o constant 1 after the first enabled edge.
- Latency: the first tick_o is high in the cycle after the Nth enabled edge following reset or clr.
- Cascade:
  - Channel k's tick_o asserts on the same edge as channel k-1's tick_o when both wrap together.
  - If en drops, the whole chain freezes.
- Arithmetic:
  - d_act-1 and floor(d_act/2) are computed in WIDTH bits.
  - Max divisor is 2^WIDTH-1; no overflow is possible because cnt never exceeds d_act-1.
- Reset mid-operation aborts immediately with no partial tick. clr with en both high gives clr priority.
- cnt_o mirrors the cnt registers directly.

Test Plan:
- Basic divide: NUM_CH=1, DEFAULT_DIV=4, en=1 from reset release -> cnt_o 0,1,2,3,0…; tick_o high one cycle after every 4th edge; sq_o 0,0,1,1 repeating.
- Odd divisor / square duty: div_ch=5, clr pulse, en=1 -> tick period 5 cycles; sq_o high 3 cycles, low 2; sq_o falls on the edge tick_o rises.
- Mid-period reload: running N=10, set div_ch=3 at cnt=4 -> the current period still completes at 10 cycles; subsequent ticks every 3 cycles; no short or runt tick.
- Idle and N=1: div_ch=0 -> tick_o=sq_o=cnt_o=0 indefinitely; then div_ch=1 -> channel starts next edge; tick_o continuously 1, sq_o 1.
- Cascade: CASCADE=1, NUM_CH=2, div_ch={3,4} (ch1=3, ch0=4), en=1 -> ch0 ticks every 4 cycles; ch1 ticks every 12 cycles, coincident with every third ch0 tick; drop en for 5 cycles -> both counters freeze, no ticks.
- Reset/clear mid-run: assert rst_n=0 asynchronously at cnt=2 -> all outputs 0 immediately, d_act=DEFAULT_DIV; separately assert clr with en=1 at cnt=3 of N=4 -> no tick, cnt restarts at 0.
